// File: rtl/wb_ram_bridge.sv
// Wishbone B3 classic slave bridging to a single-port RAM with 1-cycle read latency and stall.
// Errors out-of-range addresses and RAM stalls that exceed STALL_TIMEOUT edges.
module wb_ram_bridge #(
  parameter int unsigned RAM_BYTES     = 4096,
  parameter int unsigned STALL_TIMEOUT = 16
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_wb_cyc,
  input  logic        i_wb_stb,
  input  logic        i_wb_we,
  input  logic [3:0]  i_wb_sel,
  input  logic [31:0] i_wb_adr,
  input  logic [31:0] i_wb_dat,
  output logic [31:0] o_wb_dat,
  output logic        o_wb_ack,
  output logic        o_wb_err,
  output logic        o_ram_wen,
  output logic        o_ram_ren,
  output logic [3:0]  o_ram_ben,
  output logic [31:0] o_ram_data,
  output logic [31:0] o_ram_addr,
  input  logic [31:0] i_ram_data,
  input  logic        i_ram_stall
);

  localparam logic [31:0] RamLimit  = 32'(RAM_BYTES);
  localparam logic [7:0]  StallLast = 8'(STALL_TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StCmd, StRd, StDone} state_e;

  state_e      state_q;
  logic [7:0]  stall_cnt_q;
  logic [31:0] wb_dat_q;
  logic        wb_ack_q;
  logic        wb_err_q;
  logic        ram_wen_q;
  logic        ram_ren_q;
  logic [3:0]  ram_ben_q;
  logic [31:0] ram_data_q;
  logic [31:0] ram_addr_q;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= StIdle;
      stall_cnt_q <= '0;
      wb_dat_q    <= '0;
      wb_ack_q    <= 1'b0;
      wb_err_q    <= 1'b0;
      ram_wen_q   <= 1'b0;
      ram_ren_q   <= 1'b0;
      ram_ben_q   <= '0;
      ram_data_q  <= '0;
      ram_addr_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          stall_cnt_q <= '0;
          if (i_wb_cyc && i_wb_stb) begin
            if (i_wb_adr < RamLimit) begin
              ram_addr_q <= {i_wb_adr[31:2], 2'b00};
              ram_ben_q  <= i_wb_sel;
              ram_data_q <= i_wb_dat;
              ram_wen_q  <= i_wb_we;
              ram_ren_q  <= !i_wb_we;
              state_q    <= StCmd;
            end else begin
              wb_err_q <= 1'b1;
              state_q  <= StDone;
            end
          end
        end
        StCmd: begin
          // The latched command itself remembers read vs write until acceptance.
          if (!i_ram_stall) begin
            ram_wen_q   <= 1'b0;
            ram_ren_q   <= 1'b0;
            stall_cnt_q <= '0;
            if (ram_wen_q) begin
              wb_ack_q <= i_wb_cyc;
              state_q  <= StDone;
            end else begin
              state_q <= StRd;
            end
          end else if (stall_cnt_q == StallLast) begin
            ram_wen_q   <= 1'b0;
            ram_ren_q   <= 1'b0;
            stall_cnt_q <= '0;
            wb_err_q    <= i_wb_cyc;
            state_q     <= StDone;
          end else begin
            stall_cnt_q <= stall_cnt_q + 8'd1;
          end
        end
        StRd: begin
          // An aborted read leaves the last returned data untouched.
          if (i_wb_cyc) begin
            wb_dat_q <= i_ram_data;
            wb_ack_q <= 1'b1;
          end
          state_q <= StDone;
        end
        StDone: begin
          wb_ack_q <= 1'b0;
          wb_err_q <= 1'b0;
          state_q  <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign o_wb_dat   = wb_dat_q;
  assign o_wb_ack   = wb_ack_q;
  assign o_wb_err   = wb_err_q;
  assign o_ram_wen  = ram_wen_q;
  assign o_ram_ren  = ram_ren_q;
  assign o_ram_ben  = ram_ben_q;
  assign o_ram_data = ram_data_q;
  assign o_ram_addr = ram_addr_q;

endmodule

// File: tb/tb_wb_ram_bridge.sv
// Directed bench for wb_ram_bridge with a small byte-lane RAM model and a stall generator.
`timescale 1ns/1ps
module tb_wb_ram_bridge;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_wb_cyc = 1'b0, i_wb_stb = 1'b0, i_wb_we = 1'b0;
  logic [3:0]  i_wb_sel = '0;
  logic [31:0] i_wb_adr = '0, i_wb_dat = '0;
  logic [31:0] o_wb_dat;
  logic        o_wb_ack, o_wb_err, o_ram_wen, o_ram_ren;
  logic [3:0]  o_ram_ben;
  logic [31:0] o_ram_data, o_ram_addr;
  logic [31:0] i_ram_data = '0;
  logic        i_ram_stall = 1'b0;

  int n_cmp = 0;
  int n_fail = 0;
  int stall_left = 0;
  logic [31:0] mem [0:1023];

  wb_ram_bridge #(.RAM_BYTES(4096), .STALL_TIMEOUT(16)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_wb_cyc(i_wb_cyc), .i_wb_stb(i_wb_stb), .i_wb_we(i_wb_we),
    .i_wb_sel(i_wb_sel), .i_wb_adr(i_wb_adr), .i_wb_dat(i_wb_dat),
    .o_wb_dat(o_wb_dat), .o_wb_ack(o_wb_ack), .o_wb_err(o_wb_err),
    .o_ram_wen(o_ram_wen), .o_ram_ren(o_ram_ren), .o_ram_ben(o_ram_ben),
    .o_ram_data(o_ram_data), .o_ram_addr(o_ram_addr),
    .i_ram_data(i_ram_data), .i_ram_stall(i_ram_stall)
  );

  always #5 i_clk = ~i_clk;

  // Each negedge with stall raised stalls exactly one following posedge.
  always @(negedge i_clk) begin
    if ((o_ram_wen || o_ram_ren) && stall_left > 0) begin
      i_ram_stall = 1'b1;
      stall_left--;
    end else begin
      i_ram_stall = 1'b0;
    end
  end

  always @(posedge i_clk) begin
    if (!i_ram_stall) begin
      if (o_ram_wen)
        for (int b = 0; b < 4; b++)
          if (o_ram_ben[b]) mem[o_ram_addr[11:2]][8*b +: 8] <= o_ram_data[8*b +: 8];
      if (o_ram_ren) i_ram_data <= mem[o_ram_addr[11:2]];
    end
  end

  // Issues one request and follows it until ack/err (bounded), scrambling the request after E0.
  task automatic do_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, output int n, output logic ack, output logic err,
                         output logic [31:0] rdat, output int cmd_cycles, output logic stable,
                         output logic [31:0] cmd_addr);
    i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = we;
    i_wb_adr = adr; i_wb_dat = dat; i_wb_sel = sel;
    @(posedge i_clk); #1;
    cmd_addr = o_ram_addr;
    stable = 1'b1;
    cmd_cycles = 0;
    i_wb_adr = 32'hFFFF_FFFC; i_wb_dat = ~dat; i_wb_sel = ~sel; i_wb_we = ~we;
    n = 0;
    while (!(o_wb_ack || o_wb_err) && n < 64) begin
      if (o_ram_wen || o_ram_ren) begin
        cmd_cycles++;
        if (o_ram_addr !== cmd_addr || o_ram_wen !== we || o_ram_ren !== !we) stable = 1'b0;
      end
      @(posedge i_clk); #1;
      n++;
    end
    ack = o_wb_ack; err = o_wb_err; rdat = o_wb_dat;
    i_wb_cyc = 1'b0; i_wb_stb = 1'b0; i_wb_we = 1'b0;
    @(posedge i_clk); #1;
  endtask

  task automatic test_reset();
    i_reset = 1'b1;
    repeat (2) @(posedge i_clk);
    #1;
    n_cmp++;
    if ({o_wb_ack, o_wb_err, o_ram_wen, o_ram_ren, o_ram_ben} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b want 0", {o_wb_ack, o_wb_err, o_ram_wen, o_ram_ren, o_ram_ben});
    end
    n_cmp++;
    if ({o_wb_dat, o_ram_data, o_ram_addr} !== 96'h0) begin
      n_fail++;
      $display("FAIL reset_data: got %h want 0", {o_wb_dat, o_ram_data, o_ram_addr});
    end
    i_reset = 1'b0;
    @(posedge i_clk); #1;
  endtask

  task automatic test_write_read();
    int n, cc; logic ack, err, st; logic [31:0] rd, ca;
    do_xfer(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, n, ack, err, rd, cc, st, ca);
    n_cmp++;
    if (n !== 1 || ack !== 1'b1 || err !== 1'b0) begin
      n_fail++; $display("FAIL wr_latency: got n=%0d ack=%b err=%b want n=1 ack=1 err=0", n, ack, err);
    end
    n_cmp++;
    if (ca !== 32'h10 || cc !== 1) begin
      n_fail++; $display("FAIL wr_cmd: got addr=%h cycles=%0d want addr=10 cycles=1", ca, cc);
    end
    do_xfer(1'b0, 32'h13, 32'h0, 4'hF, n, ack, err, rd, cc, st, ca);
    n_cmp++;
    if (n !== 2 || ack !== 1'b1 || rd !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL rd_basic: got n=%0d ack=%b dat=%h want n=2 ack=1 dat=deadbeef", n, ack, rd);
    end
    n_cmp++;
    if (ca !== 32'h10) begin
      n_fail++; $display("FAIL rd_addr_align: got %h want 00000010", ca);
    end
  endtask

  task automatic test_byte_lanes();
    int n, cc; logic ack, err, st; logic [31:0] rd, ca;
    do_xfer(1'b1, 32'h10, 32'h11223344, 4'h5, n, ack, err, rd, cc, st, ca);
    do_xfer(1'b0, 32'h10, 32'h0, 4'hF, n, ack, err, rd, cc, st, ca);
    n_cmp++;
    if (rd !== 32'hDE22BE44) begin
      n_fail++; $display("FAIL sel_partial: got %h want de22be44", rd);
    end
    do_xfer(1'b1, 32'h10, 32'h55555555, 4'h0, n, ack, err, rd, cc, st, ca);
    n_cmp++;
    if (ack !== 1'b1 || cc !== 1) begin
      n_fail++; $display("FAIL sel_zero_ack: got ack=%b wen_cycles=%0d want ack=1 wen_cycles=1", ack, cc);
    end
    do_xfer(1'b0, 32'h10, 32'h0, 4'hF, n, ack, err, rd, cc, st, ca);
    n_cmp++;
    if (rd !== 32'hDE22BE44) begin
      n_fail++; $display("FAIL sel_zero_data: got %h want de22be44", rd);
    end
  endtask

  task automatic test_stall_read();
    int n, cc; logic ack, err, st; logic [31:0] rd, ca;
    stall_left = 5;
    do_xfer(1'b0, 32'h10, 32'h0, 4'hF, n, ack, err, rd, cc, st, ca);
    n_cmp++;
    if (n !== 7 || ack !== 1'b1 || rd !== 32'hDE22BE44) begin
      n_fail++; $display("FAIL stall_read: got n=%0d ack=%b dat=%h want n=7 ack=1 dat=de22be44", n, ack, rd);
    end
    n_cmp++;
    if (cc !== 6 || st !== 1'b1) begin
      n_fail++; $display("FAIL stall_hold: got ren_cycles=%0d stable=%b want 6 and 1", cc, st);
    end
  endtask

  task automatic test_out_of_range();
    int n, cc; logic ack, err, st; logic [31:0] rd, ca;
    do_xfer(1'b1, 32'h1000, 32'h12345678, 4'hF, n, ack, err, rd, cc, st, ca);
    n_cmp++;
    if (n !== 0 || err !== 1'b1 || ack !== 1'b0 || cc !== 0) begin
      n_fail++;
      $display("FAIL oor_err: got n=%0d err=%b ack=%b ram_cycles=%0d want 0 1 0 0", n, err, ack, cc);
    end
    n_cmp++;
    if (o_wb_err !== 1'b0 || o_wb_ack !== 1'b0 || rd !== 32'hDE22BE44) begin
      n_fail++; $display("FAIL oor_pulse: got err=%b ack=%b dat=%h want 0 0 de22be44", o_wb_err, o_wb_ack, rd);
    end
  endtask

  task automatic test_timeout();
    int n, cc; logic ack, err, st; logic [31:0] rd, ca;
    stall_left = 1000;
    do_xfer(1'b0, 32'h10, 32'h0, 4'hF, n, ack, err, rd, cc, st, ca);
    stall_left = 0;
    n_cmp++;
    if (n !== 16 || err !== 1'b1 || ack !== 1'b0 || cc !== 16) begin
      n_fail++;
      $display("FAIL timeout_err: got n=%0d err=%b ack=%b ren_cycles=%0d want 16 1 0 16", n, err, ack, cc);
    end
    n_cmp++;
    if (o_ram_ren !== 1'b0 || o_wb_err !== 1'b0) begin
      n_fail++; $display("FAIL timeout_drop: got ren=%b err=%b want 0 0", o_ram_ren, o_wb_err);
    end
    do_xfer(1'b0, 32'h10, 32'h0, 4'hF, n, ack, err, rd, cc, st, ca);
    n_cmp++;
    if (n !== 2 || ack !== 1'b1 || rd !== 32'hDE22BE44) begin
      n_fail++; $display("FAIL timeout_next: got n=%0d ack=%b dat=%h want 2 1 de22be44", n, ack, rd);
    end
  endtask

  task automatic test_reset_in_cmd();
    int n, cc; logic ack, err, st; logic [31:0] rd, ca;
    stall_left = 1000;
    i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = 1'b1;
    i_wb_adr = 32'h20; i_wb_dat = 32'hCAFEF00D; i_wb_sel = 4'hF;
    repeat (2) @(posedge i_clk);
    #1;
    i_reset = 1'b1;
    @(posedge i_clk); #1;
    n_cmp++;
    if ({o_wb_ack, o_wb_err, o_ram_wen, o_ram_ren, o_ram_ben, o_ram_data, o_ram_addr, o_wb_dat} !== 104'h0) begin
      n_fail++; $display("FAIL reset_cmd: got wen=%b addr=%h dat=%h want all 0", o_ram_wen, o_ram_addr, o_wb_dat);
    end
    i_reset = 1'b0; stall_left = 0;
    i_wb_cyc = 1'b0; i_wb_stb = 1'b0; i_wb_we = 1'b0;
    @(posedge i_clk); #1;
    do_xfer(1'b0, 32'h20, 32'h0, 4'hF, n, ack, err, rd, cc, st, ca);
    n_cmp++;
    if (n !== 2 || ack !== 1'b1 || rd !== 32'h0) begin
      n_fail++; $display("FAIL reset_dropped: got n=%0d ack=%b dat=%h want 2 1 00000000", n, ack, rd);
    end
  endtask

  task automatic test_abort();
    int n, cc, hits; logic ack, err, st; logic [31:0] rd, ca;
    stall_left = 3;
    hits = 0;
    cc = 0;
    i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = 1'b1;
    i_wb_adr = 32'h30; i_wb_dat = 32'h0BADCAFE; i_wb_sel = 4'hF;
    @(posedge i_clk); #1;
    i_wb_cyc = 1'b0; i_wb_stb = 1'b0; i_wb_we = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (o_wb_ack || o_wb_err) hits++;
      if (o_ram_wen) cc++;
      @(posedge i_clk); #1;
    end
    n_cmp++;
    if (hits !== 0 || cc !== 4) begin
      n_fail++; $display("FAIL abort_silent: got ack_err=%0d wen_cycles=%0d want 0 and 4", hits, cc);
    end
    do_xfer(1'b0, 32'h30, 32'h0, 4'hF, n, ack, err, rd, cc, st, ca);
    n_cmp++;
    if (n !== 2 || ack !== 1'b1 || rd !== 32'h0BADCAFE) begin
      n_fail++; $display("FAIL abort_written: got n=%0d ack=%b dat=%h want 2 1 0badcafe", n, ack, rd);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    test_reset();
    test_write_read();
    test_byte_lanes();
    test_stall_read();
    test_out_of_range();
    test_timeout();
    test_reset_in_cmd();
    test_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
